// File: rtl/alu_req_resp.sv
// Handshaked ALU responder: one operation in flight, single-cycle logic/arith/shift ops,
// iterative shift-add multiply, registered result/flags/tag held until the response retires.
module alu_req_resp #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_carry,
  output logic             resp_ovf,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 ovf_s_q, ovf_s_d;

  logic [WIDTH-1:0]     resp_result_q, resp_result_d;
  logic                 resp_zero_q, resp_zero_d;
  logic                 resp_carry_q, resp_carry_d;
  logic                 resp_ovf_q, resp_ovf_d;
  logic [TAG_W-1:0]     resp_tag_q, resp_tag_d;

  logic                 accept;
  logic [WIDTH:0]       mul_sum;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;
  logic                 alu_ovf;
  logic [WIDTH:0]       sum_w;
  logic [WIDTH:0]       diff_w;
  logic [2*WIDTH-1:0]   shl_w;
  logic [2*WIDTH-1:0]   shr_w;
  logic [SH_W-1:0]      sh;

  assign req_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && resp_ready);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == S_DONE);

  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_carry  = resp_carry_q;
  assign resp_ovf    = resp_ovf_q;
  assign resp_tag    = resp_tag_q;

  // Single-cycle datapath, evaluated from the registered operands.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    sh        = b_q[SH_W-1:0];
    sum_w     = {1'b0, a_q} + {1'b0, b_q};
    diff_w    = {1'b0, a_q} - {1'b0, b_q};
    shl_w     = {{WIDTH{1'b0}}, a_q} << sh;
    shr_w     = {a_q, {WIDTH{1'b0}}} >> sh;
    unique case (op_q)
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
        alu_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = diff_w[WIDTH];
        alu_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin
        alu_res   = shl_w[WIDTH-1:0];
        alu_carry = |shl_w[2*WIDTH-1:WIDTH];
      end
      OP_SHR: begin
        alu_res   = shr_w[2*WIDTH-1:WIDTH];
        alu_carry = |shr_w[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // Next-state and datapath control. acc holds the staged single-cycle result
  // (carry in bit WIDTH) or the running shift-add product with B in its low half.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    tag_d         = tag_q;
    acc_d         = acc_q;
    ovf_s_d       = ovf_s_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_carry_d  = resp_carry_q;
    resp_ovf_d    = resp_ovf_q;
    resp_tag_d    = resp_tag_q;
    mul_sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};

    unique case (state_q)
      S_IDLE: ;
      S_EXEC, S_MUL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (state_q == S_EXEC) begin
            acc_d   = {{(WIDTH-1){1'b0}}, alu_carry, alu_res};
            ovf_s_d = alu_ovf;
          end else if (acc_q[0]) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
          end
        end else begin
          resp_result_d = acc_q[WIDTH-1:0];
          resp_zero_d   = (acc_q[WIDTH-1:0] == '0);
          resp_carry_d  = (state_q == S_MUL) ? |acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH];
          resp_ovf_d    = (state_q == S_EXEC) && ovf_s_q;
          resp_tag_d    = tag_q;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new request can only be accepted from IDLE or a retiring DONE.
    if (accept) begin
      a_d     = req_a;
      b_d     = req_b;
      op_d    = req_op;
      tag_d   = req_tag;
      acc_d   = {{WIDTH{1'b0}}, req_b};
      state_d = (req_op == OP_MUL) ? S_MUL : S_EXEC;
      cnt_d   = (req_op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_carry_q  <= 1'b0;
      resp_ovf_q    <= 1'b0;
      resp_tag_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_carry_q  <= resp_carry_d;
      resp_ovf_q    <= resp_ovf_d;
      resp_tag_q    <= resp_tag_d;
    end
  end

  // Operand and working registers are only meaningful while the FSM says so.
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    op_q    <= op_d;
    tag_q   <= tag_d;
    acc_q   <= acc_d;
    ovf_s_q <= ovf_s_d;
  end

endmodule

// File: tb/tb_alu_req_resp.sv
// Bench for alu_req_resp (WIDTH=8): directed vector table, reset-mid-MUL,
// backpressure with same-edge retire/accept, and a random stream against a reference model.
module tb_alu_req_resp;

  localparam int W  = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [2:0]    req_op;
  logic [TW-1:0] req_tag;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_result;
  logic          resp_zero;
  logic          resp_carry;
  logic          resp_ovf;
  logic [TW-1:0] resp_tag;

  always #5 clk = ~clk;

  alu_req_resp #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_zero  (resp_zero),
    .resp_carry (resp_carry),
    .resp_ovf   (resp_ovf),
    .resp_tag   (resp_tag)
  );

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         o;
  } vec_t;

  typedef struct packed {
    logic [W-1:0]  r;
    logic          z;
    logic          c;
    logic          o;
    logic [TW-1:0] tag;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[15];
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    int g;
    g         = 0;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    req_valid = 1'b1;
    #1;
    while (!req_ready && g < 50) begin
      tick();
      g++;
    end
    chk("issue_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [TW-1:0] tag);
    int   ia, ib, sa, sb, p, sh, ss;
    exp_t e;
    ia = int'(a);
    ib = int'(b);
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    sh = ib % 8;
    p  = 0;
    e  = '0;
    case (op)
      3'd0: begin p = ia + ib; e.c = (p > 255); ss = sa + sb; e.o = (ss > 127) || (ss < -128); end
      3'd1: begin p = ia - ib; e.c = (ia < ib); ss = sa - sb; e.o = (ss > 127) || (ss < -128); end
      3'd2: p = ia & ib;
      3'd3: p = ia | ib;
      3'd4: p = ia ^ ib;
      3'd5: begin p = ia << sh; e.c = (p > 255); end
      3'd6: begin p = ia >> sh; e.c = ((ia % (1 << sh)) != 0); end
      default: begin p = ia * ib; e.c = (p > 255); end
    endcase
    e.r   = 8'(p & 255);
    e.z   = (e.r == 8'h00);
    e.tag = tag;
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int            lat;
    int            seen;
    int            issued, retired, cyc;
    logic          pending, want, rr;
    logic [2:0]    rop;
    logic [W-1:0]  ra, rb;
    logic [TW-1:0] rtag;
    exp_t          e;

    //            op    a      b      res    z     c     o
    vecs[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{3'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{3'd5, 8'h81, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'd6, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd4, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd5, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd6, 8'h81, 8'h0C, 8'h08, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'd7, 8'hA5, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'd7, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{3'd7, 8'h0F, 8'h03, 8'h2D, 1'b0, 1'b0, 1'b0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    req_tag    = '0;
    resp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_fields", {19'd0, resp_result, resp_zero, resp_carry, resp_ovf, resp_tag}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
    tick();

    resp_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, TW'(i));
      wait_resp(lat);
      chk($sformatf("vec%0d_latency", i), lat, (vecs[i].op == 3'd7) ? 32'd9 : 32'd2);
      chk($sformatf("vec%0d_result", i), {24'd0, resp_result}, {24'd0, vecs[i].res});
      chk($sformatf("vec%0d_flags", i), {29'd0, resp_zero, resp_carry, resp_ovf},
          {29'd0, vecs[i].z, vecs[i].c, vecs[i].o});
      chk($sformatf("vec%0d_tag", i), {28'd0, resp_tag}, i);
    end
    tick();

    // Reset three cycles into a multiply: nothing may come out of it.
    issue(3'd7, 8'hFF, 8'hFF, 4'h5);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("midmul_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("midmul_rst_fields", {19'd0, resp_result, resp_zero, resp_carry, resp_ovf, resp_tag}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("midmul_release_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    repeat (15) begin
      tick();
      if (resp_valid) seen++;
    end
    chk("midmul_no_stale", seen, 0);

    // Backpressure on an XOR, then retire it on the edge that accepts the next request.
    resp_ready = 1'b0;
    issue(3'd4, 8'h5A, 8'h0F, 4'h3);
    wait_resp(lat);
    chk("bp_latency", lat, 2);
    req_op    = 3'd0;
    req_a     = 8'h01;
    req_b     = 8'h02;
    req_tag   = 4'h4;
    req_valid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d", k),
          {18'd0, resp_valid, req_ready, resp_result, resp_zero, resp_carry, resp_ovf, resp_tag},
          {18'd0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 4'h3});
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_ready_on_retire", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_retired", {31'd0, resp_valid}, 32'd0);
    wait_resp(lat);
    chk("bp_next_latency", lat, 2);
    chk("bp_next_resp", {20'd0, resp_result, resp_tag}, {20'd0, 8'h03, 4'h4});
    tick();

    // Random stream with random valid/ready.
    issued  = 0;
    retired = 0;
    cyc     = 0;
    pending = 1'b0;
    rop     = '0;
    ra      = '0;
    rb      = '0;
    rtag    = '0;
    while (retired < 1000 && cyc < 30000) begin
      if (!pending && issued < 1000) begin
        rop     = 3'($urandom_range(0, 7));
        ra      = 8'($urandom_range(0, 255));
        rb      = 8'($urandom_range(0, 255));
        rtag    = TW'(issued);
        pending = 1'b1;
      end
      want       = pending && ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      req_op     = rop;
      req_a      = ra;
      req_b      = rb;
      req_tag    = rtag;
      req_valid  = !want;
      #1;
      rr        = req_ready;
      req_valid = want;
      #1;
      chk("rnd_ready_vs_valid", {31'd0, req_ready}, {31'd0, rr});
      if (req_valid && req_ready) begin
        q.push_back(model(rop, ra, rb, rtag));
        issued++;
        pending = 1'b0;
      end
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_resp", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("rnd_resp%0d", retired),
              {17'd0, resp_result, resp_zero, resp_carry, resp_ovf, resp_tag}, {17'd0, e});
        end
        retired++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    req_valid = 1'b0;
    chk("rnd_retired", retired, 1000);
    chk("rnd_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_req_resp.md
Name: alu_req_resp

Overview:
- Sequential, handshaked ALU responder for the ALU op set; replaces the bare combinational a/b/op→result interface.
- A requester issues operations on a valid/ready request channel. The block executes them (single-cycle for logic/arith/shift, iterative shift-add for multiply) and returns each result with flags and the request tag on a valid/ready response channel.
- One operation is in flight at a time. Back-to-back issue is allowed when a response retires in the same cycle.

Parameters:
WIDTH, 8, operand/result width in bits (≥4, power of 2)
TAG_W, 4, width of the request tag echoed on the response

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  block accepts request this cycle
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
req_op  input  3  opcode
req_tag  input  TAG_W  request identifier
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_result  output  WIDTH  result
resp_zero  output  1  result == 0
resp_carry  output  1  carry/borrow/shift-out/multiply-overflow
resp_ovf  output  1  signed overflow (ADD/SUB only, else 0)
resp_tag  output  TAG_W  tag of the request that produced this response

Behaviour:
- Opcodes:
  - 000 ADD: {carry,result}=a+b.
  - 001 SUB: result=a-b; carry=1 when a<b unsigned (borrow).
  - 010 AND, 011 OR, 100 XOR: carry=0.
  - 101 SHL by b[log2(WIDTH)-1:0]: carry=OR of bits shifted out.
  - 110 SHR logical, same shift amount: carry=OR of bits shifted out.
  - 111 MUL unsigned: result=low WIDTH bits of product; carry=1 when high WIDTH bits are nonzero.
- ovf for ADD/SUB: standard two's-complement sign rule; 0 for all other ops.
- FSM states:
  - IDLE
  - EXEC (single-cycle ops)
  - MUL (WIDTH iterations of shift-add, one bit of B per cycle, 2·WIDTH accumulator)
  - DONE (response held)
- Transitions:
  - On handshake (req_valid && req_ready): operands, op and tag are registered. Next state is MUL if op==111, else EXEC.
  - EXEC→DONE after 1 cycle.
  - MUL→DONE after WIDTH cycles.
  - DONE→IDLE on resp_ready, or DONE→EXEC/MUL if a new request is accepted in the same cycle.
- req_ready = (state==IDLE) || (state==DONE && resp_ready). This is a combinational path from resp_ready; it must not depend on req_valid.
- Latency, request handshake at edge N:
  - Non-MUL: resp_valid rises after edge N+2.
  - MUL: resp_valid rises after edge N+WIDTH+1.
  - Response fields are registered and stable from the resp_valid rise until the response handshake.
- resp_valid is high only in DONE. While resp_valid=1 && resp_ready=0, all resp_* outputs hold.
- Inputs are sampled only at the request handshake. Changes on req_* at other times have no effect.
- Reset (asynchronous, any state, including mid-MUL):
  - state=IDLE; the in-flight operation is discarded and no response is produced.
  - resp_valid=0; resp_result, resp_zero, resp_carry, resp_ovf and resp_tag all 0.
  - req_ready=1 in the first cycle after rst deasserts.
- MUL boundary cases:
  - b=0 gives result 0, zero=1, carry=0.
  - a=b=2^WIDTH-1 gives result 1, carry=1.
- Shift amount 0 gives result=a, carry=0.

Test Plan:
- Reset mid-MUL: WIDTH=8, issue MUL a=0xFF b=0xFF, assert rst 3 cycles later → resp_valid stays 0, all resp_* read 0, req_ready=1 after release, and no stale response appears.
- ADD boundaries (WIDTH=8, resp_ready tied 1):
  - 0x7F+0x01 → 0x80, ovf=1, carry=0, zero=0.
  - 0xFF+0x01 → 0x00, zero=1, carry=1, ovf=0.
  - resp_valid rises exactly 2 edges after each handshake.
- SUB and shifts:
  - 0x00-0x01 → 0xFF, carry=1.
  - SHL 0x81 by 1 → 0x02, carry=1.
  - SHR 0x81 by 0 → 0x81, carry=0.
- MUL: 0xFF×0xFF → result 0x01, carry=1, resp_valid rises 9 edges after the handshake. 0x0F×0x03 → 0x2D, carry=0.
- Backpressure: hold resp_ready=0 for 5 cycles after an XOR (tag 0x3) completes → resp_* stable, req_ready=0 throughout. Raise resp_ready with req_valid high (tag 0x4) → tag 0x3 retires and tag 0x4 is accepted on the same edge. Tags return in order 0x3, 0x4.
- Random stream: 1000 random ops, random valid/ready toggling → every response matches the reference model. Each tag is returned exactly once and in order. req_ready never depends on req_valid.
